// File: rtl/lava_wall_engine.sv
// Hazard wall that advances rightward in sub-pixel steps once the player has moved.
// Start delay, boost-driven speed-up with a ceiling, per-level enable, freeze and restart.
module lava_wall_engine #(
    parameter int         X_W         = 10,
    parameter int         SCREEN_W    = 640,
    parameter int         WALL_W      = 10,
    parameter int         DELAY_TICKS = 120,
    parameter int         FRAC_W      = 4,
    parameter int         SPEED_W     = 7,
    parameter int         SPEED_INIT  = 16,
    parameter int         SPEED_STEP  = 4,
    parameter int         SPEED_MAX   = 64,
    parameter logic [3:0] LEVEL_MASK  = 4'b0001
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               game_tick,
    input  logic               any_input_level,
    input  logic               speed_boost_pulse,
    input  logic               freeze,
    input  logic               restart,
    input  logic [X_W-1:0]     player_x,
    input  logic [1:0]         level,
    output logic [X_W-1:0]     lava_wall_x,
    output logic [SPEED_W-1:0] lava_speed,
    output logic               lava_active,
    output logic               hit_lava_wall,
    output logic [2:0]         lava_state
);

    localparam int ACC_W = X_W + FRAC_W;
    localparam int DLY_W = $clog2(DELAY_TICKS + 1);
    localparam logic [ACC_W-1:0]   ACC_MAX  = ACC_W'((SCREEN_W - WALL_W) << FRAC_W);
    localparam logic [SPEED_W-1:0] SPD_INIT = SPEED_W'(SPEED_INIT);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DELAY    = 3'd1,
        ST_ADVANCE  = 3'd2,
        ST_CAUGHT   = 3'd3,
        ST_DISABLED = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [DLY_W-1:0]   delay_cnt_q, delay_cnt_d;
    logic               hit_q, hit_d;
    logic               active_q, active_d;

    logic [ACC_W:0]     acc_sum_s;
    logic [ACC_W-1:0]   acc_sat_s;
    logic [SPEED_W:0]   boost_sum_s;
    logic [SPEED_W-1:0] speed_boosted_s;
    logic               hit_s;

    // Saturating arithmetic and the catch test against the pre-update wall edge
    always_comb begin
        acc_sum_s       = {1'b0, acc_q} + (ACC_W+1)'(speed_q);
        acc_sat_s       = (acc_sum_s > {1'b0, ACC_MAX}) ? ACC_MAX : acc_sum_s[ACC_W-1:0];
        boost_sum_s     = {1'b0, speed_q} + (SPEED_W+1)'(SPEED_STEP);
        speed_boosted_s = (boost_sum_s > (SPEED_W+1)'(SPEED_MAX)) ? SPEED_W'(SPEED_MAX)
                                                                  : boost_sum_s[SPEED_W-1:0];
        hit_s = ({1'b0, acc_q[ACC_W-1:FRAC_W]} + (X_W+1)'(WALL_W)) >= {1'b0, player_x};
    end

    // Next-state logic: restart beats freeze, freeze beats tick processing
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        speed_d     = speed_q;
        delay_cnt_d = delay_cnt_q;
        hit_d       = 1'b0;
        if (restart) begin
            state_d     = ST_IDLE;
            acc_d       = '0;
            speed_d     = SPD_INIT;
            delay_cnt_d = '0;
        end else if (freeze || !game_tick) begin
            state_d = state_q;
        end else if (!LEVEL_MASK[level]) begin
            state_d     = ST_DISABLED;
            acc_d       = '0;
            speed_d     = SPD_INIT;
            delay_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_input_level) begin
                        state_d     = ST_DELAY;
                        delay_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DELAY: begin
                    delay_cnt_d = delay_cnt_q + DLY_W'(1);
                    if (speed_boost_pulse) begin
                        speed_d = speed_boosted_s;
                    end else begin
                        speed_d = speed_q;
                    end
                    if (delay_cnt_q == DLY_W'(DELAY_TICKS - 1)) begin
                        state_d = ST_ADVANCE;
                    end else begin
                        state_d = ST_DELAY;
                    end
                end
                ST_ADVANCE: begin
                    if (speed_boost_pulse) begin
                        speed_d = speed_boosted_s;
                    end else begin
                        speed_d = speed_q;
                    end
                    if (hit_s) begin
                        hit_d   = 1'b1;
                        state_d = ST_CAUGHT;
                    end else begin
                        acc_d = acc_sat_s;
                    end
                end
                ST_CAUGHT:   state_d = ST_CAUGHT;
                ST_DISABLED: state_d = ST_IDLE;
                default:     state_d = ST_IDLE;
            endcase
        end
        active_d = (state_d == ST_ADVANCE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            speed_q     <= SPD_INIT;
            delay_cnt_q <= '0;
            hit_q       <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            speed_q     <= speed_d;
            delay_cnt_q <= delay_cnt_d;
            hit_q       <= hit_d;
            active_q    <= active_d;
        end
    end

    assign lava_wall_x   = acc_q[ACC_W-1:FRAC_W];
    assign lava_speed    = speed_q;
    assign lava_active   = active_q;
    assign hit_lava_wall = hit_q;
    assign lava_state    = state_q;

endmodule

// File: tb/tb_lava_wall_engine.sv
// Self-checking bench for lava_wall_engine: directed scenarios then random traffic,
// all compared against an integer-arithmetic model of the wall's rules.
module tb_lava_wall_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       game_tick = 1'b0, any_input_level = 1'b0, speed_boost_pulse = 1'b0;
    logic       freeze = 1'b0, restart = 1'b0;
    logic [9:0] player_x = 10'd1023;
    logic [1:0] level = 2'd0;
    logic [9:0] lava_wall_x;
    logic [6:0] lava_speed;
    logic       lava_active, hit_lava_wall;
    logic [2:0] lava_state;

    int n_checks = 0;
    int n_errors = 0;
    int hit_seen = 0;

    // Model: position in 1/16 px, state as plain numbers 0..4
    int m_st, m_pos, m_spd, m_ticks_in_delay, m_hit;

    lava_wall_engine dut (
        .clk(clk), .rst(rst), .game_tick(game_tick), .any_input_level(any_input_level),
        .speed_boost_pulse(speed_boost_pulse), .freeze(freeze), .restart(restart),
        .player_x(player_x), .level(level), .lava_wall_x(lava_wall_x),
        .lava_speed(lava_speed), .lava_active(lava_active),
        .hit_lava_wall(hit_lava_wall), .lava_state(lava_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_pos = 0; m_spd = 16; m_ticks_in_delay = 0; m_hit = 0;
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_clock();
        m_hit = 0;
        if (restart) begin
            model_reset();
        end else if (!freeze && game_tick) begin
            if (level != 2'd0) begin
                m_st = 4; m_pos = 0; m_spd = 16; m_ticks_in_delay = 0;
            end else if (m_st == 0) begin
                if (any_input_level) begin m_st = 1; m_ticks_in_delay = 0; end
            end else if (m_st == 1) begin
                m_ticks_in_delay++;
                if (speed_boost_pulse) m_spd = min_i(m_spd + 4, 64);
                if (m_ticks_in_delay == 120) m_st = 2;
            end else if (m_st == 2) begin
                if ((m_pos / 16) + 10 >= int'(player_x)) begin
                    m_hit = 1; m_st = 3;
                end else begin
                    m_pos = min_i(m_pos + m_spd, 630 * 16);
                end
                if (speed_boost_pulse) m_spd = min_i(m_spd + 4, 64);
            end else if (m_st == 4) begin
                m_st = 0;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("wall_x", int'(lava_wall_x), m_pos / 16);
        check_eq("speed",  int'(lava_speed),  m_spd);
        check_eq("state",  int'(lava_state),  m_st);
        check_eq("hit",    int'(hit_lava_wall), m_hit);
        check_eq("active", int'(lava_active), (m_st == 2) ? 1 : 0);
        if (hit_lava_wall) hit_seen++;
    endtask

    task automatic cyc(input logic tk, input logic inp, input logic bst,
                       input logic frz, input logic rs);
        @(negedge clk);
        game_tick = tk; any_input_level = inp; speed_boost_pulse = bst;
        freeze = frz; restart = rs;
        @(posedge clk);
        model_clock();
        #1;
        compare_all();
    endtask

    task automatic ticks(input int n, input logic inp, input logic bst);
        for (int i = 0; i < n; i++) cyc(1'b1, inp, bst, 1'b0, 1'b0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    int wall_before, speed_before;

    initial begin
        model_reset();
        #12 rst = 1'b1;
        #1 compare_all();

        // Start delay and first movement
        ticks(1, 1'b1, 1'b0);
        check_eq("delay_entry", int'(lava_state), 1);
        ticks(119, 1'b0, 1'b0);
        check_eq("delay_119", int'(lava_state), 1);
        ticks(1, 1'b0, 1'b0);
        check_eq("advance_entry", int'(lava_state), 2);
        ticks(5, 1'b0, 1'b0);
        check_eq("wall_after_5", int'(lava_wall_x), 5);
        ticks(32, 1'b0, 1'b0);
        check_eq("wall_37", int'(lava_wall_x), 37);

        // Async reset mid-advance
        async_reset();
        check_eq("rst_wall", int'(lava_wall_x), 0);
        check_eq("rst_speed", int'(lava_speed), 16);
        check_eq("rst_state", int'(lava_state), 0);

        // Boosts during delay, then saturation
        ticks(1, 1'b1, 1'b0);
        ticks(3, 1'b0, 1'b1);
        ticks(117, 1'b0, 1'b0);
        check_eq("boost3_speed", int'(lava_speed), 28);
        ticks(4, 1'b0, 1'b0);
        check_eq("boost3_wall", int'(lava_wall_x), 7);
        ticks(20, 1'b0, 1'b1);
        check_eq("speed_sat", int'(lava_speed), 64);

        // Freeze with boosts holds everything
        wall_before = int'(lava_wall_x); speed_before = int'(lava_speed);
        for (int i = 0; i < 30; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("freeze_wall", int'(lava_wall_x), wall_before);
        check_eq("freeze_speed", int'(lava_speed), speed_before);

        // Clamp at right edge, player far away
        hit_seen = 0;
        ticks(200, 1'b0, 1'b0);
        check_eq("clamp_wall", int'(lava_wall_x), 630);
        check_eq("no_hit", hit_seen, 0);

        // Level gate
        level = 2'd1;
        ticks(1, 1'b0, 1'b0);
        check_eq("gate_state", int'(lava_state), 4);
        check_eq("gate_wall", int'(lava_wall_x), 0);
        level = 2'd0;
        ticks(1, 1'b0, 1'b0);
        check_eq("ungate_state", int'(lava_state), 0);

        // Catch at wall_x 10 with player at 20
        player_x = 10'd20;
        ticks(1, 1'b1, 1'b0);
        ticks(120, 1'b0, 1'b0);
        ticks(10, 1'b0, 1'b0);
        check_eq("pre_hit_wall", int'(lava_wall_x), 10);
        hit_seen = 0;
        ticks(1, 1'b0, 1'b0);
        check_eq("hit_pulse", int'(hit_lava_wall), 1);
        check_eq("caught_state", int'(lava_state), 3);
        ticks(3, 1'b0, 1'b0);
        check_eq("hit_once", hit_seen, 1);
        check_eq("caught_wall", int'(lava_wall_x), 10);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("restart_state", int'(lava_state), 0);
        check_eq("restart_wall", int'(lava_wall_x), 0);

        // Random traffic against the model
        for (int i = 0; i < 8000; i++) begin
            if ((i % 300) == 0) player_x = 10'($urandom_range(60, 1023));
            level = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 999) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
